// File: rtl/tcb_if.sv
// TCB bus instance: one request channel (vld/wen/adr/wdt) with rdy backpressure
// and a fixed one-cycle read data return (rdt).
interface tcb_if #(
   parameter int ADR = 32,
   parameter int DAT = 32
) ();
   logic           vld;
   logic           wen;
   logic [ADR-1:0] adr;
   logic [DAT-1:0] wdt;
   logic [DAT-1:0] rdt;
   logic           rdy;

   modport man (output vld, wen, adr, wdt, input  rdt, rdy);
   modport sub (input  vld, wen, adr, wdt, output rdt, rdy);
endinterface

// File: rtl/tcb_arb2.sv
// Two-manager round-robin arbiter in front of one TCB subordinate.
// Requests pass through combinationally; read data is steered to the issuing manager.
module tcb_arb2 #(
   parameter int ADR = 32,
   parameter int DAT = 32
) (
   input  logic clk,
   input  logic rst,
   tcb_if.sub   man0,
   tcb_if.sub   man1,
   tcb_if.man   sub
);

   logic           pri;
   logic           lck;
   logic           gnt_q;
   logic           own;
   logic           own_vld;
   logic           gnt;
   logic           vld_mux;
   logic           wen_mux;
   logic [ADR-1:0] adr_mux;
   logic [DAT-1:0] wdt_mux;
   logic           trn;

   // A stalled request keeps its grant so the manager's held fields stay on the bus.
   always_comb begin
      if (lck)
         gnt = gnt_q;
      else if (man0.vld != man1.vld)
         gnt = man1.vld;
      else
         gnt = pri;
   end

   assign vld_mux = gnt ? man1.vld : man0.vld;
   assign wen_mux = gnt ? man1.wen : man0.wen;
   assign adr_mux = gnt ? man1.adr : man0.adr;
   assign wdt_mux = gnt ? man1.wdt : man0.wdt;

   assign sub.vld = vld_mux;
   assign sub.wen = wen_mux;
   assign sub.adr = adr_mux;
   assign sub.wdt = wdt_mux;

   assign man0.rdy = ~gnt & sub.rdy;
   assign man1.rdy =  gnt & sub.rdy;

   assign trn = vld_mux & sub.rdy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pri     <= 1'b0;
         lck     <= 1'b0;
         gnt_q   <= 1'b0;
         own     <= 1'b0;
         own_vld <= 1'b0;
      end else begin
         if (trn) begin
            pri <= ~gnt;
            lck <= 1'b0;
         end else if (vld_mux) begin
            lck   <= 1'b1;
            gnt_q <= gnt;
         end
         // own may change here while the previous response is still on rdt this cycle
         if (trn && !wen_mux) begin
            own     <= gnt;
            own_vld <= 1'b1;
         end else begin
            own_vld <= 1'b0;
         end
      end
   end

   assign man0.rdt = (own_vld && !own) ? sub.rdt : '0;
   assign man1.rdt = (own_vld &&  own) ? sub.rdt : '0;

endmodule

// File: tb/tb_tcb_arb2.sv
// Randomised + directed bench for tcb_arb2 with a cycle-level reference model
// and a scoreboard queue drained by an independent monitor.
module tb_tcb_arb2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   tcb_if #(.ADR(32), .DAT(32)) m0 ();
   tcb_if #(.ADR(32), .DAT(32)) m1 ();
   tcb_if #(.ADR(32), .DAT(32)) s  ();

   tcb_arb2 #(.ADR(32), .DAT(32)) dut (
      .clk  (clk),
      .rst  (rst),
      .man0 (m0),
      .man1 (m1),
      .sub  (s)
   );

   typedef struct {
      int          cyc;
      bit          vld;
      bit          g;
      bit          srdy;
      bit          wen;
      logic [31:0] adr;
      logic [31:0] wdt;
      logic [31:0] rdt0;
      logic [31:0] rdt1;
   } exp_t;

   typedef struct {
      int cyc;
      bit g;
   } rsp_t;

   exp_t exp_q[$];
   rsp_t rsp_q[$];
   int   n_chk = 0;
   int   n_err = 0;
   int   cyc_n = 0;

   // reference state: next tie winner, and who is left waiting on a stalled offer
   bit m_pri  = 1'b0;
   bit m_hold = 1'b0;
   bit m_who  = 1'b0;

   task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cycle %0d: got %h want %h", nm, c, act, exp);
      end
   endtask

   task automatic cyc(input bit r,
                      input bit v0, input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                      input bit v1, input bit w1, input logic [31:0] a1, input logic [31:0] d1,
                      input bit srdy, input logic [31:0] rdt,
                      output bit trn, output bit g);
      exp_t e;
      rsp_t p;
      rst = r;
      m0.vld = v0; m0.wen = w0; m0.adr = a0; m0.wdt = d0;
      m1.vld = v1; m1.wen = w1; m1.adr = a1; m1.wdt = d1;
      s.rdy = srdy; s.rdt = rdt;
      if (r) begin
         m_pri = 1'b0; m_hold = 1'b0; m_who = 1'b0;
         rsp_q.delete();
      end
      if (m_hold)        g = m_who;
      else if (v0 != v1) g = v1;
      else               g = m_pri;
      e.cyc  = cyc_n;
      e.vld  = g ? v1 : v0;
      e.g    = g;
      e.srdy = srdy;
      e.wen  = g ? w1 : w0;
      e.adr  = g ? a1 : a0;
      e.wdt  = g ? d1 : d0;
      e.rdt0 = '0;
      e.rdt1 = '0;
      if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc_n) begin
         p = rsp_q.pop_front();
         if (p.g) e.rdt1 = rdt;
         else     e.rdt0 = rdt;
      end
      trn = e.vld & srdy;
      if (!r) begin
         if (trn) begin
            m_pri  = !g;
            m_hold = 1'b0;
            if (!e.wen) rsp_q.push_back('{cyc_n + 1, g});
         end else if (e.vld) begin
            m_hold = 1'b1;
            m_who  = g;
         end
      end
      exp_q.push_back(e);
      @(posedge clk); #1;
      cyc_n++;
   endtask

   task automatic idle(input bit r, input logic [31:0] rdt);
      bit t, g;
      cyc(r, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 1, rdt, t, g);
   endtask

   // monitor: whatever the DUT presents this cycle is compared against the oldest expectation
   always @(negedge clk) begin : mon
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("sub_vld",  e.cyc, s.vld,  e.vld);
         chk("man0_rdy", e.cyc, m0.rdy, e.srdy & !e.g);
         chk("man1_rdy", e.cyc, m1.rdy, e.srdy &  e.g);
         if (e.vld) begin
            chk("sub_wen", e.cyc, s.wen, e.wen);
            chk("sub_adr", e.cyc, s.adr, e.adr);
            chk("sub_wdt", e.cyc, s.wdt, e.wdt);
         end
         chk("man0_rdt", e.cyc, m0.rdt, e.rdt0);
         chk("man1_rdt", e.cyc, m1.rdt, e.rdt1);
      end
   end

   initial begin
      bit          t, g, r;
      bit          pv[2];
      bit          pw[2];
      logic [31:0] pa[2];
      logic [31:0] pd[2];

      rst = 1'b1;
      m0.vld = 0; m0.wen = 0; m0.adr = '0; m0.wdt = '0;
      m1.vld = 0; m1.wen = 0; m1.adr = '0; m1.wdt = '0;
      s.rdy = 0; s.rdt = '0;
      @(posedge clk); #1;

      // reset held with both managers requesting
      repeat (3) cyc(1, 1, 0, 32'h100, 32'h0, 1, 0, 32'h200, 32'h0, 1, $urandom, t, g);
      // continuous contention: alternate starting at man0
      repeat (8) cyc(0, 1, 0, 32'h100, 32'h0, 1, 0, 32'h200, 32'h0, 1, $urandom, t, g);

      // stall lock on man1, man0 joins mid-stall
      cyc(0, 0, 0, 32'h300, 32'h0, 1, 1, 32'h8, 32'h55, 0, $urandom, t, g);
      cyc(0, 1, 0, 32'h300, 32'h0, 1, 1, 32'h8, 32'h55, 0, $urandom, t, g);
      cyc(0, 1, 0, 32'h300, 32'h0, 1, 1, 32'h8, 32'h55, 0, $urandom, t, g);
      cyc(0, 1, 0, 32'h300, 32'h0, 1, 1, 32'h8, 32'h55, 1, $urandom, t, g);
      cyc(0, 1, 0, 32'h300, 32'h0, 0, 0, 32'h0, 32'h0,  1, $urandom, t, g);

      // read steering, back to back
      cyc(0, 1, 0, 32'h10, 32'h0, 0, 0, 32'h0,  32'h0, 1, $urandom, t, g);
      cyc(0, 0, 0, 32'h0,  32'h0, 1, 0, 32'h20, 32'h0, 1, 32'hAAAA5555, t, g);
      idle(0, 32'h12345678);
      idle(0, $urandom);

      // write produces no response
      cyc(0, 0, 0, 32'h0, 32'h0, 1, 1, 32'h4, 32'hDEADBEEF, 1, $urandom, t, g);
      idle(0, $urandom);

      // reset right after a read transfer drops the response and clears pri
      cyc(0, 1, 0, 32'h40, 32'h0, 0, 0, 32'h0, 32'h0, 1, $urandom, t, g);
      idle(1, 32'hCAFEF00D);
      cyc(0, 1, 0, 32'h44, 32'h0, 1, 0, 32'h48, 32'h0, 1, $urandom, t, g);
      idle(0, $urandom);

      // reset releases a held lock
      cyc(0, 0, 0, 32'h0,  32'h0, 1, 0, 32'h50, 32'h0, 0, $urandom, t, g);
      cyc(1, 0, 0, 32'h0,  32'h0, 1, 0, 32'h50, 32'h0, 0, $urandom, t, g);
      cyc(0, 1, 0, 32'h60, 32'h0, 1, 0, 32'h50, 32'h0, 1, $urandom, t, g);
      idle(0, $urandom);

      // random traffic; a manager holds its request until transferred
      pv[0] = 0; pv[1] = 0;
      pw[0] = 0; pw[1] = 0;
      pa[0] = '0; pa[1] = '0;
      pd[0] = '0; pd[1] = '0;
      repeat (3000) begin
         for (int i = 0; i < 2; i++) begin
            if (!pv[i] && $urandom_range(99) < 60) begin
               pv[i] = 1;
               pw[i] = 1'($urandom_range(1));
               pa[i] = $urandom;
               pd[i] = $urandom;
            end
         end
         r = ($urandom_range(199) == 0);
         cyc(r, pv[0], pw[0], pa[0], pd[0], pv[1], pw[1], pa[1], pd[1],
             ($urandom_range(99) < 70), $urandom, t, g);
         if (t) pv[g] = 0;
      end
      idle(0, $urandom);

      for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_chk++;
         n_err++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
